router_ingress_queue: RTL and testbench
=======================================

# router_ingress_queue

Ingress buffer that sits directly upstream of `simple_router`. It accepts (address, data) words over a valid/ready handshake and stores them in a DEPTH-entry FIFO. It presents the head entry as `din_en`/`addr`/`din`, which connect straight to the router's identically named inputs. Downstream acceptance is signalled by `out_ready`, so bursts are absorbed without loss while the consumer stalls.

## Interface
- `WIDTH`, 32, data width; must match the router's `WIDTH`.
- `DEPTH`, 8, FIFO entries; power of two, at least 2.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  queue can accept a word this cycle.
- `in_addr`  in  2  destination port (0..3) of the incoming word.
- `in_data`  in  WIDTH  payload of the incoming word.
- `out_ready`  in  1  downstream consumes the presented word this cycle.
- `din_en`  out  1  head entry valid; drives the router's `din_en`.
- `addr`  out  2  destination of the head entry; drives the router's `addr`.
- `din`  out  WIDTH  payload of the head entry; drives the router's `din`.
- `count`  out  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.

## Operation
- Storage: DEPTH entries of {addr[1:0], data[WIDTH-1:0]}.
  - Pointers: write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy: `count` register.
- Push: when `in_valid && in_ready`, write {in_addr, in_data} at the write pointer, then increment the write pointer.
- Pop: when `din_en && out_ready`, increment the read pointer.
- `count` update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `in_ready` = (count != DEPTH). A full queue rejects a push even if a pop happens in the same cycle; there is no same-cycle pass-through.
- `din_en` = (count != 0). The queue is show-ahead: `addr` and `din` show the entry at the read pointer.
- When empty, `addr` = 2'b00 and `din` = 0. The outputs never show stale data, so the router outputs stay at all-zero.
- Reset clears both pointers and `count`. Memory contents need not be cleared.
- Reset values:
  - `in_ready` = 1
  - `din_en` = 0
  - `addr` = 0
  - `din` = 0
  - `count` = 0
- Reset asserted mid-operation discards all stored words immediately, without waiting for a clock edge.
- Words leave in exactly the order they were accepted. Address and data always stay paired.
- `in_addr` and `in_data` are ignored when the handshake does not complete.

## Timing
- Latency from push to presentation is 1 cycle. A word pushed at edge N into an empty queue shows `din_en`=1 after edge N.
- Throughput is 1 word per cycle in and 1 word per cycle out, sustained when 0 < count < DEPTH.
- `in_ready`, `din_en` and `count` depend only on registered state. There is no combinational path from `in_valid` or `out_ready` to any output.
- `addr` and `din` follow the read pointer and storage. They may be a mux of registered storage, settling within the same cycle as the pointer change.
- Empty with simultaneous push and pop: the pop is not possible because `din_en`=0. The push lands and `count` becomes 1.
- Full with `in_valid`=1 and `out_ready`=1: the pop occurs, the push is refused, `count` becomes DEPTH-1, and `in_ready`=1 in the next cycle.
- Both pointers wrap from DEPTH-1 to 0 with no gap and no lost entry.
- `out_ready`=0 holds `din_en`, `addr` and `din` stable for as long as the stall lasts.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1.
  - Required during and after: `in_ready`=1, `din_en`=0, `addr`=0, `din`=0, `count`=0.
- Single word: push {addr=2'b10, data=32'hF0} with `out_ready`=0.
  - Next cycle: `din_en`=1, `addr`=2'b10, `din`=32'hF0, `count`=1.
  - Then raise `out_ready` for 1 cycle: `din_en`=0, `din`=0, `count`=0.
- Fill/full: push 8 words, data 1..8 with addr = data%4, while `out_ready`=0.
  - Required: `count`=8, `in_ready`=0.
  - A 9th push attempt is ignored.
  - Draining with `out_ready`=1 yields 1..8 in order, with the matching addresses.
- Full with simultaneous push and pop: at `count`=8, drive `in_valid`=1 with data 32'hAA and `out_ready`=1.
  - Required: `count`=7, 32'hAA not stored.
  - The next cycle accepts 32'hAA, and it emerges last.
- Wrap-around: stream 20 words with `in_valid`=1 and `out_ready`=1 every cycle after the first.
  - Required: output order equals input order, `count` stays at 1, no bubble after the first word.
- Mid-operation reset: with `count`=5, pulse `rst` asynchronously between edges.
  - Required immediately: `din_en`=0, `count`=0, `in_ready`=1.
  - A subsequent push of 32'h55 to addr 3 is the first word presented.

Source files
------------

// File: rtl/router_ingress_queue.sv
// Ingress FIFO feeding simple_router: valid/ready in, show-ahead head entry out.
// Each entry is {addr, data}, so the destination and the payload always stay paired.
module router_ingress_queue #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_addr,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       out_ready,
    output logic                       din_en,
    output logic [1:0]                 addr,
    output logic [WIDTH-1:0]           din,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = WIDTH + 2;
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;
    logic [EW-1:0] head;

    // Handshakes and occupancy flags come only from registered state.
    always_comb begin
        in_ready = (count_q != Full);
        din_en   = (count_q != '0);
        push     = in_valid && in_ready;
        pop      = din_en && out_ready;
    end

    // Pointer and occupancy next-state; a full queue refuses a push even while popping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; reset discards all stored words at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the empty-gating below hides whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_addr, in_data};
        end
    end

    // Show-ahead head entry, forced to zero when empty so the router never sees stale data.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (din_en) begin
            addr = head[EW-1:WIDTH];
            din  = head[WIDTH-1:0];
        end else begin
            addr = 2'b00;
            din  = '0;
        end
        count = count_q;
    end

endmodule

// File: tb/tb_router_ingress_queue.sv
// Bench for router_ingress_queue: directed scenarios plus random traffic against a queue model.
module tb_router_ingress_queue;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_addr;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             din_en;
    logic [1:0]       addr;
    logic [WIDTH-1:0] din;
    logic [3:0]       count;

    int n_tests;
    int n_fail;

    // Reference: words in acceptance order, each {addr, data}.
    logic [WIDTH+1:0] model_q[$];

    router_ingress_queue #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .out_ready(out_ready),
        .din_en   (din_en),
        .addr     (addr),
        .din      (din),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Compare every output with what the model says should be presented.
    task automatic check_model(input string tag);
        int sz;
        sz = model_q.size();
        check_eq({tag, ".count"}, 64'(count), 64'(sz));
        check_eq({tag, ".in_ready"}, 64'(in_ready), 64'(sz < DEPTH));
        check_eq({tag, ".din_en"}, 64'(din_en), 64'(sz > 0));
        if (sz > 0) begin
            check_eq({tag, ".addr"}, 64'(addr), 64'(model_q[0][WIDTH+1:WIDTH]));
            check_eq({tag, ".din"}, 64'(din), 64'(model_q[0][WIDTH-1:0]));
        end else begin
            check_eq({tag, ".addr"}, 64'(addr), 64'd0);
            check_eq({tag, ".din"}, 64'(din), 64'd0);
        end
    endtask

    // One clock: drive inputs, apply the queue rules to the model, then check #1 after the edge.
    task automatic step(input logic v, input logic [1:0] a, input logic [WIDTH-1:0] d,
                        input logic r, input string tag);
        bit do_push, do_pop;
        in_valid  = v;
        in_addr   = a;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        do_push = v && (model_q.size() < DEPTH);
        do_pop  = r && (model_q.size() > 0);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back({a, d});
        #1;
        check_model(tag);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 2'b00;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held for two cycles with in_valid high.
        #2;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_addr  = 2'b11;
        in_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("rst.in_ready", 64'(in_ready), 64'd1);
            check_eq("rst.din_en", 64'(din_en), 64'd0);
            check_eq("rst.addr", 64'(addr), 64'd0);
            check_eq("rst.din", 64'(din), 64'd0);
            check_eq("rst.count", 64'(count), 64'd0);
        end
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        model_q.delete();
        step(0, 0, 0, 0, "post_rst");

        // Single word.
        step(1, 2'b10, 32'hF0, 0, "single_push");
        check_eq("single.din_en", 64'(din_en), 64'd1);
        check_eq("single.addr", 64'(addr), 64'd2);
        check_eq("single.din", 64'(din), 64'hF0);
        step(0, 0, 0, 1, "single_pop");
        check_eq("single_pop.count", 64'(count), 64'd0);

        // Fill to full, then a refused 9th push, then drain in order.
        for (int i = 1; i <= 8; i++) step(1, 2'(i % 4), 32'(i), 0, "fill");
        check_eq("full.count", 64'(count), 64'd8);
        check_eq("full.in_ready", 64'(in_ready), 64'd0);
        step(1, 2'b01, 32'h99, 0, "push_when_full");
        check_eq("ninth.count", 64'(count), 64'd8);
        for (int i = 1; i <= 8; i++) begin
            check_eq("drain.din", 64'(din), 64'(i));
            check_eq("drain.addr", 64'(addr), 64'(i % 4));
            step(0, 0, 0, 1, "drain");
        end

        // Full with simultaneous push and pop: pop wins, push refused, retried next cycle.
        for (int i = 1; i <= 8; i++) step(1, 2'(i % 4), 32'(i), 0, "refill");
        step(1, 2'b00, 32'hAA, 1, "full_push_pop");
        check_eq("fpp.count", 64'(count), 64'd7);
        check_eq("fpp.in_ready", 64'(in_ready), 64'd1);
        step(1, 2'b00, 32'hAA, 0, "retry_aa");
        check_eq("retry.count", 64'(count), 64'd8);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1, "drain_aa");
        check_eq("aa_last.din", 64'(din), 64'hAA);
        check_eq("aa_last.count", 64'(count), 64'd1);
        step(0, 0, 0, 1, "drain_aa_end");

        // Streaming across the pointer wrap: count stays at 1, no bubbles.
        step(1, 2'b01, 32'h1000, 0, "stream_first");
        for (int i = 1; i < 20; i++) begin
            step(1, 2'(i), 32'h1000 + 32'(i), 1, "stream");
            check_eq("stream.count", 64'(count), 64'd1);
            check_eq("stream.din", 64'(din), 64'h1000 + 64'(i));
        end
        step(0, 0, 0, 1, "stream_end");

        // Asynchronous reset between edges with 5 words stored.
        for (int i = 0; i < 5; i++) step(1, 2'(i), 32'h300 + 32'(i), 0, "pre_async");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst.din_en", 64'(din_en), 64'd0);
        check_eq("arst.count", 64'(count), 64'd0);
        check_eq("arst.in_ready", 64'(in_ready), 64'd1);
        #1;
        rst = 1'b0;
        model_q.delete();
        step(1, 2'b11, 32'h55, 0, "after_arst");
        check_eq("arst_first.addr", 64'(addr), 64'd3);
        check_eq("arst_first.din", 64'(din), 64'h55);
        step(0, 0, 0, 1, "after_arst_pop");

        // Random traffic in phases biased towards filling, draining and balanced flow.
        for (int ph = 0; ph < 3; ph++) begin
            for (int i = 0; i < 150; i++) begin
                logic v, r;
                case (ph)
                    0:       begin v = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
                    1:       begin v = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
                    default: begin v = $urandom_range(0, 1) == 1; r = $urandom_range(0, 1) == 1; end
                endcase
                step(v, 2'($urandom), 32'($urandom), r, "random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
